iter_divider: RTL and testbench
===============================

Name: iter_divider

Overview:
- Multi-cycle radix-2 integer divider; the inverse counterpart to the Booth-based multiplier in the Calculator datapath.
- Executes RV64M DIV/DIVU/REM/REMU and the W forms DIVW/DIVUW/REMW/REMUW.
- Sits beside the multiplier behind the execute stage and talks to it through a valid/ready request channel and a valid/ready response channel.
- Holds at most one operation in flight; supports flush on pipeline redirect.

Parameters:
- XLEN, 64, operand and result width in bits.
- CNT_W, 7, iteration counter width; must hold values up to XLEN.

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- rst, in, 1, synchronous active-high reset.
- flush, in, 1, aborts any operation in flight.
- in_valid, in, 1, request valid.
- in_ready, out, 1, divider can accept a request.
- is_signed, in, 1, 1 = DIV/REM, 0 = DIVU/REMU.
- want_rem, in, 1, 1 = return remainder, 0 = return quotient.
- is_word, in, 1, 1 = W variant; uses operand bits [31:0] only.
- dividend, in, XLEN, rs1 value.
- divisor, in, XLEN, rs2 value.
- out_valid, out, 1, result valid.
- out_ready, in, 1, consumer accepts the result.
- result, out, XLEN, quotient or remainder, per want_rem.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, in_ready=1, out_valid=0, result=0, counter=0.
- States: IDLE, CALC, DONE.
- in_ready=1 only in IDLE. A request is accepted when in_valid&in_ready&~flush; the block captures operands and all control bits in that cycle.

Operand preparation (in the accept cycle):
- W variant: operands are the low 32 bits, sign-extended if is_signed, otherwise zero-extended. Iteration count N=32.
- Otherwise N=XLEN.
- Signed operation: divide the magnitudes; record quotient sign = sign(dividend)^sign(divisor) and remainder sign = sign(dividend).

Special cases (decided in the accept cycle; go straight to DONE, so out_valid is high the next cycle):
- Divide by zero (divisor zero over the effective width): quotient = all ones, remainder = dividend.
- Signed overflow (dividend = most-negative value, divisor = -1, at the effective width): quotient = dividend, remainder = 0.

CALC:
- One restoring step per cycle: shift the {rem,quo} pair left by 1, subtract the divisor magnitude, keep the difference if it is non-negative, and set the quotient LSB accordingly.
- The counter counts from N-1 down to 0. When the step at counter=0 completes, the next state is DONE.
- Accept at cycle t gives out_valid at cycle t+N+1: 33 cycles for W, 65 for XLEN=64.

DONE:
- result is registered on entry to DONE, after sign correction (two's-complement negate where the recorded sign says so).
- W variant: bits [31:0] of the corrected value are sign-extended to XLEN. This applies to unsigned W forms too, per RV64.
- out_valid=1, and result is held stable until out_valid&out_ready. On that handshake the next state is IDLE, with in_ready=1 in the following cycle; no same-cycle re-accept.
- Backpressure: out_valid, result and state are unchanged while out_ready=0.

flush:
- In any state, the next state is IDLE and out_valid=0 next cycle; any result in DONE is discarded.
- flush together with in_valid in IDLE: the request is not accepted.
- flush has priority over out_ready.
- rst has priority over flush.

Other rules:
- in_valid in CALC or DONE is ignored.
- The result does not depend on operand or control inputs after the accept cycle.

Test Plan:
- DIV 7 / -2 (0xFFFF_FFFF_FFFF_FFFE), want_rem=0 -> result 0xFFFF_FFFF_FFFF_FFFD at exactly accept+65. REM on the same operands -> 0x1.
- DIVU 0xFFFF_FFFF_FFFF_FFFF / 0x10 -> 0x0FFF_FFFF_FFFF_FFFF. REMU on the same operands -> 0xF.
- Divide by zero: DIV 0x1234 / 0 -> 0xFFFF_FFFF_FFFF_FFFF at accept+1. REM 0x1234 / 0 -> 0x1234.
- Signed overflow:
  - DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM -> 0.
  - DIVW with dividend 0x0000_0000_8000_0000 and divisor 0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000.
- W forms:
  - DIVUW 0xABCD_0000_FFFF_FFFE / 0x2 -> 0x7FFF_FFFF at accept+33.
  - REMW -7 / 3 -> 0xFFFF_FFFF_FFFF_FFFF.
- Handshake and flush:
  - Hold out_ready=0 for 10 cycles: out_valid and result stay stable, and in_ready stays 0.
  - Assert flush at accept+20: out_valid stays 0 and in_ready=1 next cycle; a new DIV 100/7 then returns 14.

Source files
------------

// File: rtl/iter_divider_if.sv
// Request/response channel between the execute stage and the iterative divider.
// The master side issues operations and consumes results; the slave side is the divider.
interface iter_divider_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic            is_signed;
  logic            want_rem;
  logic            is_word;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, is_signed, want_rem, is_word, dividend, divisor, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, is_signed, want_rem, is_word, dividend, divisor, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and W forms.
// One operation in flight; divide-by-zero and signed overflow bypass the iteration.
// Latency from accept edge to out_valid: N+1 cycles (N = 32 for W forms, XLEN otherwise),
// one cycle for the special cases.
module iter_divider #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  iter_divider_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            want_rem_q, want_rem_d;
  logic            is_word_q, is_word_d;

  // Operand preparation signals (valid in the accept cycle only)
  logic [XLEN-1:0] a_eff, b_eff, min_eff;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN-1:0] quo_init;
  logic [XLEN-1:0] spec_val;
  logic            sign_a, sign_b;
  logic            div_zero, sgn_ovf;

  // Restoring step and final correction signals
  logic [XLEN:0]   rem_sh, diff;
  logic            ge;
  logic [XLEN-1:0] step_rem, step_quo;
  logic [XLEN-1:0] fin_q, fin_r, fin_sel;

  // W results always take bit 31 as the sign, unsigned forms included
  function automatic logic [XLEN-1:0] word_fix(input logic [XLEN-1:0] val, input logic word);
    word_fix = word ? {{(XLEN-32){val[31]}}, val[31:0]} : val;
  endfunction

  // Extend operands to the effective width, detect special cases, take magnitudes
  always_comb begin
    if (bus.is_word) begin
      a_eff   = bus.is_signed ? {{(XLEN-32){bus.dividend[31]}}, bus.dividend[31:0]}
                              : {{(XLEN-32){1'b0}}, bus.dividend[31:0]};
      b_eff   = bus.is_signed ? {{(XLEN-32){bus.divisor[31]}}, bus.divisor[31:0]}
                              : {{(XLEN-32){1'b0}}, bus.divisor[31:0]};
      min_eff = {{(XLEN-31){1'b1}}, 31'b0};
    end else begin
      a_eff   = bus.dividend;
      b_eff   = bus.divisor;
      min_eff = {1'b1, {(XLEN-1){1'b0}}};
    end
    sign_a   = bus.is_signed & a_eff[XLEN-1];
    sign_b   = bus.is_signed & b_eff[XLEN-1];
    mag_a    = sign_a ? (~a_eff + 1'b1) : a_eff;
    mag_b    = sign_b ? (~b_eff + 1'b1) : b_eff;
    div_zero = (b_eff == '0);
    sgn_ovf  = bus.is_signed && (b_eff == '1) && (a_eff == min_eff);
    // W dividends sit in the upper half so that 32 shifts drain them fully into rem
    quo_init = bus.is_word ? {mag_a[31:0], {(XLEN-32){1'b0}}} : mag_a;
    if (div_zero) begin
      spec_val = bus.want_rem ? a_eff : '1;
    end else begin
      spec_val = bus.want_rem ? '0 : a_eff;
    end
  end

  // One restoring step plus sign correction of the step's outcome
  always_comb begin
    rem_sh   = {rem_q, quo_q[XLEN-1]};
    diff     = rem_sh - {1'b0, dvsr_q};
    ge       = ~diff[XLEN];
    step_rem = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    step_quo = {quo_q[XLEN-2:0], ge};
    fin_q    = qneg_q ? (~step_quo + 1'b1) : step_quo;
    fin_r    = rneg_q ? (~step_rem + 1'b1) : step_rem;
    fin_sel  = want_rem_q ? fin_r : fin_q;
  end

  // Next-state and datapath update; flush overrides every state transition
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvsr_d     = dvsr_q;
    result_d   = result_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    want_rem_d = want_rem_q;
    is_word_d  = is_word_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && !flush) begin
          want_rem_d = bus.want_rem;
          is_word_d  = bus.is_word;
          qneg_d     = sign_a ^ sign_b;
          rneg_d     = sign_a;
          rem_d      = '0;
          quo_d      = quo_init;
          dvsr_d     = mag_b;
          if (div_zero || sgn_ovf) begin
            result_d = word_fix(spec_val, bus.is_word);
            cnt_d    = '0;
            state_d  = DONE;
          end else begin
            cnt_d   = bus.is_word ? CNT_W'(31) : CNT_W'(XLEN-1);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == '0) begin
          result_d = word_fix(fin_sel, is_word_q);
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      result_q   <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      want_rem_q <= 1'b0;
      is_word_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvsr_q     <= dvsr_d;
      result_q   <= result_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      want_rem_q <= want_rem_d;
      is_word_q  <= is_word_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;

endmodule

// File: tb/tb_iter_divider.sv
// Directed-vector bench for iter_divider: arithmetic results, exact latency,
// special cases, backpressure and flush behaviour.
module tb_iter_divider;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  iter_divider_if #(.XLEN(64)) bus ();

  iter_divider #(.XLEN(64), .CNT_W(7)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Present a request for one cycle, then scramble the inputs to prove they were captured
  task automatic issue(input logic sgn, input logic rem, input logic word,
                       input logic [63:0] a, input logic [63:0] b, input string tag);
    int w = 0;
    while (bus.in_ready !== 1'b1 && w < 200) begin
      @(posedge clk); #1; w++;
    end
    check_val({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.is_signed = sgn;
    bus.want_rem  = rem;
    bus.is_word   = word;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.is_signed = ~sgn;
    bus.want_rem  = ~rem;
    bus.is_word   = ~word;
    bus.dividend  = ~a;
    bus.divisor   = ~b;
  endtask

  // Count edges after the accept edge until out_valid; N edges means accept+N+1
  task automatic wait_result(input int exp_lat, input logic [63:0] exp, input string tag);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check_val({tag, " latency"}, 64'(n), 64'(exp_lat));
    check_val({tag, " result"}, bus.result, exp);
    $display("op %-12s result=%h edges_after_accept=%0d", tag, bus.result, n);
  endtask

  task automatic retire(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_val({tag, " retire out_valid"}, 64'(bus.out_valid), 64'd0);
    check_val({tag, " retire in_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  task automatic op(input logic sgn, input logic rem, input logic word,
                    input logic [63:0] a, input logic [63:0] b,
                    input logic [63:0] exp, input int exp_lat, input string tag);
    issue(sgn, rem, word, a, b, tag);
    wait_result(exp_lat, exp, tag);
    retire(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.is_signed = 1'b0;
    bus.want_rem  = 1'b0;
    bus.is_word   = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset in_ready", 64'(bus.in_ready), 64'd1);
    check_val("reset out_valid", 64'(bus.out_valid), 64'd0);
    check_val("reset result", bus.result, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full-width signed and unsigned
    op(1, 0, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 64, "div7/-2");
    op(1, 1, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 64, "rem7/-2");
    op(0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 64, "divu");
    op(0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'hF, 64, "remu");
    op(1, 0, 0, 64'h8000_0000_0000_0000, 64'd2, 64'hC000_0000_0000_0000, 64, "divmin/2");

    // Special cases
    op(1, 0, 0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, "div/0");
    op(1, 1, 0, 64'h1234, 64'd0, 64'h1234, 0, "rem/0");
    op(1, 0, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 0, "divovf");
    op(1, 1, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0, "removf");
    op(1, 0, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0, "divwovf");
    op(0, 1, 1, 64'h0000_0000_8000_0005, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_8000_0005, 0, "remuw/0");

    // W forms
    op(0, 0, 1, 64'hABCD_0000_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 32, "divuw");
    op(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 32, "remw-7/3");
    op(0, 0, 1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 32, "divuw/1");

    // Backpressure: result and handshake state frozen while out_ready=0; in_valid ignored
    issue(0, 0, 0, 64'd1000, 64'd10, "bp");
    wait_result(64, 64'd100, "bp");
    bus.in_valid = 1'b1;
    bus.divisor  = 64'd0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_val("bp hold out_valid", 64'(bus.out_valid), 64'd1);
      check_val("bp hold result", bus.result, 64'd100);
      check_val("bp hold in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid = 1'b0;
    retire("bp");
    $display("op %-12s held 10 cycles under backpressure", "bp");

    // Flush in the middle of an iteration (cycle accept+20)
    issue(1, 0, 0, 64'h1000, 64'd3, "flush");
    repeat (19) @(posedge clk);
    #1;
    check_val("flush pre out_valid", 64'(bus.out_valid), 64'd0);
    check_val("flush pre in_ready", 64'(bus.in_ready), 64'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_val("flush post out_valid", 64'(bus.out_valid), 64'd0);
    check_val("flush post in_ready", 64'(bus.in_ready), 64'd1);
    $display("op %-12s aborted at accept+20", "flush");

    // Flush with a request in IDLE: not accepted (a div-by-zero would otherwise finish next cycle)
    bus.is_signed = 1'b1;
    bus.want_rem  = 1'b0;
    bus.is_word   = 1'b0;
    bus.dividend  = 64'd5;
    bus.divisor   = 64'd0;
    bus.in_valid  = 1'b1;
    flush         = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    flush         = 1'b0;
    check_val("flush+req in_ready", 64'(bus.in_ready), 64'd1);
    check_val("flush+req out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    check_val("flush+req later out_valid", 64'(bus.out_valid), 64'd0);
    $display("op %-12s request dropped under flush", "flush+req");

    op(1, 0, 0, 64'd100, 64'd7, 64'd14, 64, "div100/7");

    // Flush in DONE wins over out_ready and discards the result
    issue(1, 0, 0, 64'd9, 64'd0, "flushdone");
    wait_result(0, 64'hFFFF_FFFF_FFFF_FFFF, "flushdone");
    flush         = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    flush         = 1'b0;
    bus.out_ready = 1'b0;
    check_val("flushdone out_valid", 64'(bus.out_valid), 64'd0);
    check_val("flushdone in_ready", 64'(bus.in_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
